random_instruction_generator: RTL and testbench
===============================================

RANDOM_INSTRUCTION_GENERATOR -- requirements
Module: random_instruction_generator

Interface
REQ-001 SHALL have parameter RV64I, default 0; 1 enables the AluRWType and AluIWType opcodes and the 64-bit load/store funct3 values.
REQ-002 SHALL have parameter SEED, default 32'hACE1_0001; the LFSR reset value, and it must be nonzero.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16; the width of count and index.
REQ-004 SHALL have port clock, input, 1; the single clock.
REQ-005 SHALL have port reset, input, 1; synchronous, active-high.
REQ-006 SHALL have port start, input, 1; requests a burst of count instructions.
REQ-007 SHALL have port count, input, COUNT_WIDTH; burst length, sampled when start is accepted.
REQ-008 SHALL have port opcode_enable, input, 13; per-class enable bit, indexed in REQ-013 order, sampled at start.
REQ-009 SHALL have ports seed_load, input, 1, and seed, input, 32; load the LFSR while IDLE.
REQ-010 SHALL have ports valid, output, 1; ready, input, 1; instruction, output, 32; index, output, COUNT_WIDTH (position in the burst, 0-based).
REQ-011 SHALL have ports busy, output, 1; done, output, 1 (one-cycle pulse); error, output, 1 (one-cycle pulse).

Function
REQ-012 SHALL use a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), advancing only in the DRAW_A and DRAW_B states.
REQ-013 SHALL have FSM states IDLE, DRAW_A, DRAW_B, OUT: DRAW_A latches the LFSR into A, DRAW_B latches it into B, OUT presents the instruction.
REQ-014 SHALL compute the class as A[3:0] mod N (N=13 if RV64I else 11), in order AluR, AluI, Load, S, B, Lui, Auipc, Jal, Jalr, Fence, System, AluRW, AluIW.
REQ-015 SHALL, when the drawn class is disabled, go from DRAW_B back to DRAW_A (rejection), with no output and no change to index.
REQ-016 SHALL form the base word as {B[31:7], opcode}, then overwrite the constrained fields, so that rd=A[8:4] and rs1=A[13:9] in every format.
REQ-017 SHALL constrain funct3 from A[16:14] to the legal set, indexing that set with A[16:14] mod set size:
- Load: {0,1,2,4,5}, plus {3,6} when RV64I.
- S: {0,1,2}, plus {3} when RV64I.
- B and AluRW: {0,1,4,5,6,7}.
- AluIW: {0,1,5}.
- Jalr and Fence: 0.
- System: 0 when A[20:17]>=6, else {1,2,3,5,6,7}[A[20:17]].
REQ-018 SHALL constrain funct7 as follows:
- AluR: 7'h01 if A[21]; else 7'h20 if A[22] and funct3 is 0 or 5; else 7'h00.
- AluRW: 7'h01 for funct3 4, 6 or 7; the AluR rule for funct3 0 or 5; 7'h00 for funct3 1.
- AluI and AluIW: A[22] ? 7'h20 : 7'h00.
- System with funct3=0: {7'h00, 7'h00, 7'h08, 7'h18}[A[23:22]].
- All other classes: taken from B.
REQ-019 SHALL, in IDLE, accept start when seed_load=0 and go to DRAW_A; it SHALL sample count and opcode_enable and clear index at the same edge.
REQ-020 SHALL ignore start while busy; seed_load SHALL have priority over start in IDLE.
REQ-021 SHALL, at start with count=0, stay IDLE and pulse done on the next cycle.
REQ-022 SHALL, at start with no enabled legal class (bits 11 and 12 are ignored when RV64I=0), stay IDLE and pulse error on the next cycle.
REQ-023 SHALL, in OUT, assert valid and hold instruction and index stable until ready.
REQ-024 SHALL, on a valid&&ready handshake, increment index; if index==count-1 it SHALL go to IDLE and pulse done on the next cycle, otherwise go to DRAW_A.
REQ-025 SHALL assert busy in every state except IDLE.
REQ-026 SHALL have a minimum latency of 3 cycles from start to valid, and 3 cycles from a handshake to the next valid (no rejection).
REQ-027 SHALL handle a burst of count=2^COUNT_WIDTH-1 without wrapping index.

Reset
REQ-028 SHALL, on reset, force: state IDLE, LFSR=SEED, A=B=0, valid=0, busy=0, done=0, error=0, index=0, instruction=0.
REQ-029 SHALL, when reset arrives mid-burst (including OUT with valid high), abandon the burst in the same edge with no done pulse.

Verification
REQ-030 Reset, then start with count=3, ready=1, opcode_enable all ones -> valid first seen 3 cycles after start; exactly 3 handshakes with index 0,1,2; done pulses once, the cycle after the third handshake.
REQ-031 RV64I=0, opcode_enable=13'h0001 (AluR only), count=200 -> every instruction[6:0]=7'h33; funct7 in {00,01,20}; funct7=20 only with funct3 0 or 5.
REQ-032 count=0 -> done pulse on the next cycle, valid never asserted; opcode_enable=0 with count=5 -> error pulse, busy stays 0.
REQ-033 ready low for 10 cycles in OUT -> instruction and index constant, LFSR frozen; start pulses during that window are ignored.
REQ-034 Load seed=32'h1 twice, running the same count=8 burst after each -> identical instruction sequences; reset during OUT -> valid=0 on the next cycle, no done pulse.
REQ-035 RV64I=1, opcode_enable=13'h1004 (Load, AluIW), count=1000 -> every instruction is legal per REQ-017/018; both classes are observed.

Source files
------------

// File: rtl/random_instruction_generator.sv
// Random RISC-V instruction generator: draws two LFSR words per candidate,
// rejects disabled classes and legalises funct3/funct7 before presenting the word.
module random_instruction_generator #(
  parameter int          RV64I       = 0,
  parameter logic [31:0] SEED        = 32'hACE1_0001,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic [12:0]            opcode_enable,
  input  logic                   seed_load,
  input  logic [31:0]            seed,
  output logic                   valid,
  input  logic                   ready,
  output logic [31:0]            instruction,
  output logic [COUNT_WIDTH-1:0] index,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [1:0] {IDLE, DRAW_A, DRAW_B, OUT} state_t;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [3:0]  N_CLASSES = (RV64I != 0) ? 4'd13 : 4'd11;

  state_t                 r_state, w_next;
  logic [31:0]            r_lfsr, w_lfsr_next;
  logic [23:0]            r_a;
  logic [31:7]            r_b;
  logic [COUNT_WIDTH-1:0] r_count, r_index;
  logic [12:0]            r_enable, w_legal_en;
  logic                   r_done, r_error;
  logic [3:0]             w_class;
  logic                   w_class_en, w_accept, w_last;
  logic [6:0]             w_opcode, w_f7;
  logic [2:0]             w_f3;
  logic [31:0]            w_word;

  function automatic logic [6:0] aluRF7(input logic mulSel, input logic subSel,
                                        input logic [2:0] f3);
    if (mulSel) return 7'h01;
    if (subSel && (f3 == 3'd0 || f3 == 3'd5)) return 7'h20;
    return 7'h00;
  endfunction

  // Legal sets are indexed by A[16:14] modulo the set size.
  function automatic logic [2:0] loadF3(input logic [2:0] k);
    logic [2:0] j;
    j = (RV64I != 0) ? (k % 3'd7) : (k % 3'd5);
    case (j)
      3'd3:    loadF3 = 3'd4;
      3'd4:    loadF3 = 3'd5;
      3'd5:    loadF3 = 3'd3;
      default: loadF3 = j;
    endcase
  endfunction

  function automatic logic [2:0] storeF3(input logic [2:0] k);
    storeF3 = (RV64I != 0) ? {1'b0, k[1:0]} : (k % 3'd3);
  endfunction

  function automatic logic [2:0] sixF3(input logic [2:0] k);
    logic [2:0] j;
    j = k % 3'd6;
    sixF3 = (j < 3'd2) ? j : j + 3'd2;
  endfunction

  function automatic logic [2:0] iwF3(input logic [2:0] k);
    logic [2:0] j;
    j = k % 3'd3;
    iwF3 = (j == 3'd2) ? 3'd5 : j;
  endfunction

  function automatic logic [2:0] sysF3(input logic [3:0] m);
    if (m >= 4'd6)     sysF3 = 3'd0;
    else if (m < 4'd3) sysF3 = m[2:0] + 3'd1;
    else               sysF3 = m[2:0] + 3'd2;
  endfunction

  assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_MASK : 32'h0);
  assign w_legal_en  = (RV64I != 0) ? opcode_enable : {2'b00, opcode_enable[10:0]};
  assign w_accept    = start && !seed_load && (count != '0) && (w_legal_en != '0);
  assign w_class     = r_a[3:0] % N_CLASSES;
  assign w_class_en  = r_enable[w_class];
  assign w_last      = (r_index == r_count - COUNT_WIDTH'(1));

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = DRAW_A;
      DRAW_A:  w_next = DRAW_B;
      DRAW_B:  w_next = w_class_en ? OUT : DRAW_A;
      OUT:     if (ready) w_next = w_last ? IDLE : DRAW_A;
      default: w_next = IDLE;
    endcase
  end

  // The LFSR only moves while drawing, so a stalled OUT freezes the sequence.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr   <= SEED;
      r_a      <= '0;
      r_b      <= '0;
      r_count  <= '0;
      r_index  <= '0;
      r_enable <= '0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (seed_load) begin
            r_lfsr <= seed;
          end else if (start) begin
            if (count == '0)           r_done  <= 1'b1;
            else if (w_legal_en == '0) r_error <= 1'b1;
            else begin
              r_count  <= count;
              r_enable <= w_legal_en;
              r_index  <= '0;
            end
          end
        end
        DRAW_A: begin
          r_a    <= r_lfsr[23:0];
          r_lfsr <= w_lfsr_next;
        end
        DRAW_B: begin
          r_b    <= r_lfsr[31:7];
          r_lfsr <= w_lfsr_next;
        end
        OUT: begin
          if (ready) begin
            r_index <= r_index + COUNT_WIDTH'(1);
            if (w_last) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_opcode = 7'h33;
    case (w_class)
      4'd0:    w_opcode = 7'h33;
      4'd1:    w_opcode = 7'h13;
      4'd2:    w_opcode = 7'h03;
      4'd3:    w_opcode = 7'h23;
      4'd4:    w_opcode = 7'h63;
      4'd5:    w_opcode = 7'h37;
      4'd6:    w_opcode = 7'h17;
      4'd7:    w_opcode = 7'h6F;
      4'd8:    w_opcode = 7'h67;
      4'd9:    w_opcode = 7'h0F;
      4'd10:   w_opcode = 7'h73;
      4'd11:   w_opcode = 7'h3B;
      4'd12:   w_opcode = 7'h1B;
      default: w_opcode = 7'h33;
    endcase
  end

  // Fields not constrained for a class fall through from the B word.
  always_comb begin
    w_f3 = r_b[14:12];
    w_f7 = r_b[31:25];
    case (w_class)
      4'd0: begin
        w_f3 = r_a[16:14];
        w_f7 = aluRF7(r_a[21], r_a[22], r_a[16:14]);
      end
      4'd1: begin
        w_f3 = r_a[16:14];
        w_f7 = r_a[22] ? 7'h20 : 7'h00;
      end
      4'd2:       w_f3 = loadF3(r_a[16:14]);
      4'd3:       w_f3 = storeF3(r_a[16:14]);
      4'd4:       w_f3 = sixF3(r_a[16:14]);
      4'd8, 4'd9: w_f3 = 3'd0;
      4'd10: begin
        w_f3 = sysF3(r_a[20:17]);
        if (w_f3 == 3'd0) begin
          case (r_a[23:22])
            2'd2:    w_f7 = 7'h08;
            2'd3:    w_f7 = 7'h18;
            default: w_f7 = 7'h00;
          endcase
        end
      end
      4'd11: begin
        w_f3 = sixF3(r_a[16:14]);
        case (w_f3)
          3'd0, 3'd5: w_f7 = aluRF7(r_a[21], r_a[22], w_f3);
          3'd1:       w_f7 = 7'h00;
          default:    w_f7 = 7'h01;
        endcase
      end
      4'd12: begin
        w_f3 = iwF3(r_a[16:14]);
        w_f7 = r_a[22] ? 7'h20 : 7'h00;
      end
      default: ;
    endcase
    w_word = {w_f7, r_b[24:20], r_a[13:9], w_f3, r_a[8:4], w_opcode};
  end

  assign valid       = (r_state == OUT);
  assign busy        = (r_state != IDLE);
  assign instruction = valid ? w_word : 32'h0;
  assign index       = r_index;
  assign done        = r_done;
  assign error       = r_error;

endmodule

// File: tb/tb_random_instruction_generator.sv
// Self-checking bench: a reference model predicts every burst into a scoreboard
// queue; table vectors cover the immediate start responses.
module tb_random_instruction_generator;

   localparam int          CW   = 16;
   localparam logic [31:0] SEED = 32'hACE1_0001;

   logic          clock = 1'b0;
   logic          reset, start32, start64, seedLoad, ready, sel64;
   logic [CW-1:0] count;
   logic [12:0]   opEn;
   logic [31:0]   seed;

   logic          valid32, busy32, done32, error32, valid64, busy64, done64, error64;
   logic [31:0]   instr32, instr64;
   logic [CW-1:0] index32, index64;

   logic          oValid, oBusy, oDone, oError;
   logic [31:0]   oInstr;
   logic [CW-1:0] oIndex;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0]   instr;
      logic [CW-1:0] idx;
      int            draws;
   } exp_t;

   typedef struct {
      logic [CW-1:0] cnt;
      logic [12:0]   en;
      logic          sl;
      logic          expBusy;
      logic          expDone;
      logic          expError;
      string         name;
   } vec_t;

   exp_t        sb[$];
   logic [31:0] burstLog[$];
   logic [31:0] runA[$];
   logic [31:0] mLfsr[2];
   int          sawLoad = 0;
   int          sawIw = 0;
   int          lastHs = 0;

   random_instruction_generator #(.RV64I(0), .SEED(SEED), .COUNT_WIDTH(CW)) dut32 (
      .clock(clock), .reset(reset), .start(start32), .count(count),
      .opcode_enable(opEn), .seed_load(seedLoad), .seed(seed),
      .valid(valid32), .ready(ready), .instruction(instr32), .index(index32),
      .busy(busy32), .done(done32), .error(error32));

   random_instruction_generator #(.RV64I(1), .SEED(SEED), .COUNT_WIDTH(CW)) dut64 (
      .clock(clock), .reset(reset), .start(start64), .count(count),
      .opcode_enable(opEn), .seed_load(seedLoad), .seed(seed),
      .valid(valid64), .ready(ready), .instruction(instr64), .index(index64),
      .busy(busy64), .done(done64), .error(error64));

   assign oValid = sel64 ? valid64 : valid32;
   assign oBusy  = sel64 ? busy64  : busy32;
   assign oDone  = sel64 ? done64  : done32;
   assign oError = sel64 ? error64 : error32;
   assign oInstr = sel64 ? instr64 : instr32;
   assign oIndex = sel64 ? index64 : index32;

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [CW-1:0] c, input logic [12:0] e);
      count = c;
      opEn  = e;
      if (sel64) start64 = s;
      else       start32 = s;
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      mLfsr[0] = SEED;
      mLfsr[1] = SEED;
   endtask

   function automatic logic [31:0] lfsrNext(input logic [31:0] s);
      lfsrNext = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   function automatic logic [6:0] aluRRule(input logic [31:0] a, input logic [2:0] f3);
      if (a[21]) return 7'h01;
      if (a[22] && (f3 == 3'd0 || f3 == 3'd5)) return 7'h20;
      return 7'h00;
   endfunction

   function automatic logic [31:0] modelInstr(input logic [31:0] a, input logic [31:0] b, input bit rv64);
      logic [6:0]  opc[13];
      logic [2:0]  loadSet[7];
      logic [2:0]  bSet[6];
      logic [2:0]  iwSet[3];
      logic [2:0]  sysSet[6];
      logic [6:0]  sysF7[4];
      logic [31:0] w;
      logic [2:0]  f3;
      logic [6:0]  f7;
      int          cls;
      int          k;
      opc     = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73, 7'h3B, 7'h1B};
      loadSet = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
      bSet    = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      iwSet   = '{3'd0, 3'd1, 3'd5};
      sysSet  = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
      sysF7   = '{7'h00, 7'h00, 7'h08, 7'h18};
      cls = int'(a[3:0]) % (rv64 ? 13 : 11);
      k   = int'(a[16:14]);
      w   = {b[31:7], opc[cls]};
      f3  = b[14:12];
      f7  = b[31:25];
      case (cls)
         0:  begin f3 = a[16:14]; f7 = aluRRule(a, f3); end
         1:  begin f3 = a[16:14]; f7 = a[22] ? 7'h20 : 7'h00; end
         2:  f3 = rv64 ? loadSet[k % 7] : loadSet[k % 5];
         3:  f3 = rv64 ? 3'(k % 4) : 3'(k % 3);
         4:  f3 = bSet[k % 6];
         8, 9: f3 = 3'd0;
         10: begin
            f3 = (a[20:17] >= 4'd6) ? 3'd0 : sysSet[a[20:17]];
            if (f3 == 3'd0) f7 = sysF7[a[23:22]];
         end
         11: begin
            f3 = bSet[k % 6];
            if (f3 == 3'd1) f7 = 7'h00;
            else if (f3 == 3'd0 || f3 == 3'd5) f7 = aluRRule(a, f3);
            else f7 = 7'h01;
         end
         12: begin f3 = iwSet[k % 3]; f7 = a[22] ? 7'h20 : 7'h00; end
         default: ;
      endcase
      w[11:7]  = a[8:4];
      w[19:15] = a[13:9];
      w[14:12] = f3;
      w[31:25] = f7;
      return w;
   endfunction

   task automatic predictBurst(input int cnt, input logic [12:0] en, input bit rv64);
      logic [12:0] legal;
      logic [31:0] a, b;
      int          cls, draws;
      exp_t        e;
      legal = rv64 ? en : {2'b00, en[10:0]};
      for (int i = 0; i < cnt; i++) begin
         draws = 0;
         do begin
            a = mLfsr[rv64];
            mLfsr[rv64] = lfsrNext(mLfsr[rv64]);
            b = mLfsr[rv64];
            mLfsr[rv64] = lfsrNext(mLfsr[rv64]);
            draws++;
            cls = int'(a[3:0]) % (rv64 ? 13 : 11);
         end while (!legal[cls] && draws < 10000);
         e.instr = modelInstr(a, b, rv64);
         e.idx   = CW'(i);
         e.draws = draws;
         sb.push_back(e);
      end
   endtask

   // propMode 1: RV32 AluR-only properties; propMode 2: RV64 Load/AluIW legality.
   task automatic runBurst(input int cnt, input logic [12:0] en, input int readyPct,
                           input int stallCycles, input int maxCycles, input int propMode);
      int          cyc, hs, doneSeen, doneCyc, expValidCyc;
      bit          waiting, stalled, ok;
      logic [31:0] holdI;
      logic [CW-1:0] holdIdx;
      logic [2:0]  f3;
      logic [6:0]  f7;
      exp_t        e;
      sb.delete();
      burstLog.delete();
      predictBurst(cnt, en, sel64);
      hs = 0; doneSeen = 0; doneCyc = -1; lastHs = -1; stalled = 0;
      expValidCyc = 2 * sb[0].draws + 1;
      waiting = 1;
      ready = 1'b1;
      applyStimulus(1'b1, CW'(cnt), en);
      tick();
      applyStimulus(1'b0, CW'(cnt), en);
      cyc = 1;
      while (cyc < maxCycles && !(doneSeen > 0 && sb.size() == 0)) begin
         if (oError) checkOutput("unexpectedError", 32'(oError), 32'd0);
         if (oDone) begin doneSeen++; doneCyc = cyc; end
         ready = 1'b1;
         if (oValid) begin
            if (waiting) begin
               checkOutput("validLatency", 32'(cyc), 32'(expValidCyc));
               waiting = 0;
            end
            if (stallCycles > 0 && !stalled) begin
               stalled = 1;
               holdI   = oInstr;
               holdIdx = oIndex;
               ready   = 1'b0;
               for (int s = 0; s < stallCycles; s++) begin
                  applyStimulus(s[0], CW'(1), 13'h1FFF);
                  tick();
                  checkOutput("stallInstr", oInstr, holdI);
                  checkOutput("stallIndex", 32'(oIndex), 32'(holdIdx));
                  checkOutput("stallValid", 32'(oValid), 32'd1);
               end
               applyStimulus(1'b0, CW'(cnt), en);
               cyc += stallCycles;
            end
            ready = ($urandom_range(99) < readyPct) ? 1'b1 : 1'b0;
            if (ready) begin
               if (sb.size() == 0) begin
                  checkOutput("extraOutput", 32'(oValid), 32'd0);
               end else begin
                  e = sb.pop_front();
                  checkOutput("instruction", oInstr, e.instr);
                  checkOutput("index", 32'(oIndex), 32'(e.idx));
                  burstLog.push_back(oInstr);
                  hs++;
                  lastHs = cyc;
                  if (sb.size() > 0) begin
                     expValidCyc = cyc + 2 * sb[0].draws + 1;
                     waiting = 1;
                  end
                  f3 = oInstr[14:12];
                  f7 = oInstr[31:25];
                  if (propMode == 1) begin
                     checkOutput("aluROpcode", 32'(oInstr[6:0]), 32'h33);
                     ok = (f7 == 7'h00 || f7 == 7'h01 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                     checkOutput("aluRFunct7", 32'(ok), 32'd1);
                  end else if (propMode == 2) begin
                     if (oInstr[6:0] == 7'h03) begin
                        sawLoad++;
                        ok = (f3 != 3'd7);
                     end else if (oInstr[6:0] == 7'h1B) begin
                        sawIw++;
                        ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5) && (f7 == 7'h00 || f7 == 7'h20);
                     end else begin
                        ok = 0;
                     end
                     checkOutput("rv64Legal", 32'(ok), 32'd1);
                  end
               end
            end
         end
         tick();
         cyc++;
      end
      ready = 1'b1;
      checkOutput("burstComplete", 32'(doneSeen > 0 && sb.size() == 0), 32'd1);
      checkOutput("handshakes", 32'(hs), 32'(cnt));
      checkOutput("doneOnce", 32'(doneSeen), 32'd1);
      checkOutput("doneTiming", 32'(doneCyc), 32'(lastHs + 1));
      checkOutput("donePulseEnds", 32'(oDone), 32'd0);
      checkOutput("idleAfterBurst", 32'(oBusy), 32'd0);
   endtask

   vec_t vecs[5];

   initial begin
      int waitCyc;
      reset = 1'b1; start32 = 1'b0; start64 = 1'b0; seedLoad = 1'b0; ready = 1'b1;
      sel64 = 1'b0; count = '0; opEn = '0; seed = '0;
      vecs[0] = '{cnt: 16'd0, en: 13'h1FFF, sl: 1'b0, expBusy: 1'b0, expDone: 1'b1, expError: 1'b0, name: "count0"};
      vecs[1] = '{cnt: 16'd5, en: 13'h0000, sl: 1'b0, expBusy: 1'b0, expDone: 1'b0, expError: 1'b1, name: "noEnable"};
      vecs[2] = '{cnt: 16'd5, en: 13'h1800, sl: 1'b0, expBusy: 1'b0, expDone: 1'b0, expError: 1'b1, name: "rv64BitsOnly"};
      vecs[3] = '{cnt: 16'd3, en: 13'h0004, sl: 1'b1, expBusy: 1'b0, expDone: 1'b0, expError: 1'b0, name: "seedPriority"};
      vecs[4] = '{cnt: 16'd4, en: 13'h0001, sl: 1'b0, expBusy: 1'b1, expDone: 1'b0, expError: 1'b0, name: "accepted"};

      doReset();
      checkOutput("rstValid", 32'(valid32), 32'd0);
      checkOutput("rstBusy", 32'(busy32), 32'd0);
      checkOutput("rstDone", 32'(done32), 32'd0);
      checkOutput("rstError", 32'(error32), 32'd0);
      checkOutput("rstIndex", 32'(index32), 32'd0);
      checkOutput("rstInstr", instr32, 32'd0);
      checkOutput("rstBusy64", 32'(busy64), 32'd0);

      for (int v = 0; v < 5; v++) begin
         doReset();
         seedLoad = vecs[v].sl;
         seed     = SEED;
         applyStimulus(1'b1, vecs[v].cnt, vecs[v].en);
         tick();
         applyStimulus(1'b0, vecs[v].cnt, vecs[v].en);
         seedLoad = 1'b0;
         checkOutput({vecs[v].name, "_busy"}, 32'(oBusy), 32'(vecs[v].expBusy));
         checkOutput({vecs[v].name, "_done"}, 32'(oDone), 32'(vecs[v].expDone));
         checkOutput({vecs[v].name, "_error"}, 32'(oError), 32'(vecs[v].expError));
         checkOutput({vecs[v].name, "_valid"}, 32'(oValid), 32'd0);
         tick();
         checkOutput({vecs[v].name, "_busy2"}, 32'(oBusy), 32'(vecs[v].expBusy));
         checkOutput({vecs[v].name, "_pulseDone"}, 32'(oDone), 32'd0);
         checkOutput({vecs[v].name, "_pulseError"}, 32'(oError), 32'd0);
      end

      doReset();
      runBurst(3, 13'h1FFF, 100, 0, 100, 0);
      runBurst(200, 13'h0001, 100, 0, 12000, 1);
      runBurst(4, 13'h1FFF, 70, 10, 500, 0);

      for (int r = 0; r < 2; r++) begin
         seedLoad = 1'b1;
         seed     = 32'h1;
         tick();
         seedLoad = 1'b0;
         mLfsr[0] = 32'h1;
         runBurst(8, 13'h07FF, 100, 0, 500, 0);
         if (r == 0) runA = burstLog;
      end
      for (int i = 0; i < 8; i++) checkOutput("seedRepeat", burstLog[i], runA[i]);

      ready = 1'b0;
      applyStimulus(1'b1, CW'(5), 13'h1FFF);
      tick();
      applyStimulus(1'b0, CW'(5), 13'h1FFF);
      waitCyc = 0;
      while (!oValid && waitCyc < 50) begin
         tick();
         waitCyc++;
      end
      checkOutput("reachOut", 32'(oValid), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mLfsr[0] = SEED;
      mLfsr[1] = SEED;
      checkOutput("midResetValid", 32'(oValid), 32'd0);
      checkOutput("midResetBusy", 32'(oBusy), 32'd0);
      checkOutput("midResetIndex", 32'(oIndex), 32'd0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("midResetNoDone", 32'(oDone), 32'd0);
         tick();
      end
      ready = 1'b1;
      runBurst(2, 13'h1FFF, 100, 0, 200, 0);

      sel64 = 1'b1;
      doReset();
      runBurst(1000, 13'h1004, 80, 0, 40000, 2);
      checkOutput("sawLoad", 32'(sawLoad > 0), 32'd1);
      checkOutput("sawAluIW", 32'(sawIw > 0), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
